// File: rtl/mem_write_checker_if.sv
// Bus between a processor bench and mem_write_checker: table programming,
// run control, the watched CPU data-memory write port and the verdict outputs.
interface mem_write_checker_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_EXP = 4,
    parameter int unsigned TIMEOUT = 1000
);
    localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int unsigned CW = $clog2(NUM_EXP + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic              cfg_we;
    logic [IW-1:0]     cfg_idx;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [CW-1:0]     cfg_count;
    logic              start;
    logic              mem_write;
    logic [ADDR_W-1:0] data_adr;
    logic [DATA_W-1:0] write_data;
    logic              done;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [ADDR_W-1:0] fail_adr;
    logic [CW-1:0]     match_cnt;
    logic [TW-1:0]     cycle_cnt;

    // Bench / CPU side.
    modport master (
        output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
        output mem_write, data_adr, write_data,
        input  done, pass, fail, fail_code, fail_adr, match_cnt, cycle_cnt
    );

    // Checker side.
    modport slave (
        input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
        input  mem_write, data_adr, write_data,
        output done, pass, fail, fail_code, fail_adr, match_cnt, cycle_cnt
    );
endinterface

// File: rtl/mem_write_checker.sv
// In-order data-memory write checker. Compares CPU writes against a programmed
// table of (addr,data) pairs, skipping non-matching writes to IGNORE_ADR, and
// reports a registered pass/fail verdict with cause, offending address and counts.
// Optional build macro MWC_TRACE_EN: sim-only trace of matched/ignored writes and
// the verdict, stopping the simulation on entry to PASS or FAIL.
module mem_write_checker #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_EXP    = 4,
    parameter int unsigned IGNORE_ADR = 96,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    mem_write_checker_if.slave bus
);
    localparam int unsigned IW = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int unsigned CW = $clog2(NUM_EXP + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] IgnAdr = ADDR_W'(IGNORE_ADR);

    typedef enum logic [1:0] {StIdle, StRun, StPass, StFail} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] tbl_adr_q [NUM_EXP];
    logic [DATA_W-1:0] tbl_dat_q [NUM_EXP];
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     match_q, match_d;
    logic [TW-1:0]     cycle_q, cycle_d;
    logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W-1:0] fadr_q, fadr_d;
    logic              tbl_we;
    logic              hit, ign;

    // Compare the current write against the next expected entry; X/Z never match.
    always_comb begin
        hit = (bus.data_adr === tbl_adr_q[IW'(match_q)]) &&
              (bus.write_data === tbl_dat_q[IW'(match_q)]);
        ign = (bus.data_adr === IgnAdr);
    end

    // Next-state and verdict logic; start overrides everything else.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        match_d = match_q;
        cycle_d = cycle_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        fadr_d  = fadr_q;
        tbl_we  = 1'b0;
        if (bus.start) begin
            count_d = bus.cfg_count;
            match_d = '0;
            cycle_d = '0;
            fadr_d  = '0;
            pass_d  = 1'b0;
            if (bus.cfg_count == '0 || 32'(bus.cfg_count) > NUM_EXP) begin
                state_d = StFail;
                done_d  = 1'b1;
                fail_d  = 1'b1;
                code_d  = 2'd3;
            end else begin
                state_d = StRun;
                done_d  = 1'b0;
                fail_d  = 1'b0;
                code_d  = 2'd0;
            end
        end else begin
            unique case (state_q)
                StIdle: tbl_we = bus.cfg_we && (32'(bus.cfg_idx) < NUM_EXP);
                StRun: begin
                    cycle_d = cycle_q + 1'b1;
                    if (bus.mem_write && hit) begin
                        match_d = match_q + 1'b1;
                    end
                    if (bus.mem_write && hit && match_d == count_q) begin
                        state_d = StPass;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else if (bus.mem_write && !hit && !ign) begin
                        state_d = StFail;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        code_d  = 2'd1;
                        fadr_d  = bus.data_adr;
                    end else if (32'(cycle_d) == TIMEOUT) begin
                        state_d = StFail;
                        done_d  = 1'b1;
                        fail_d  = 1'b1;
                        code_d  = 2'd2;
                    end
                end
                StPass, StFail: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counters, verdict and expected-write table.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            count_q <= '0;
            match_q <= '0;
            cycle_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= 2'd0;
            fadr_q  <= '0;
            for (int i = 0; i < int'(NUM_EXP); i++) begin
                tbl_adr_q[i] <= '0;
                tbl_dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            match_q <= match_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            fadr_q  <= fadr_d;
            if (tbl_we) begin
                tbl_adr_q[bus.cfg_idx] <= bus.cfg_addr;
                tbl_dat_q[bus.cfg_idx] <= bus.cfg_data;
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.fail_code = code_q;
    assign bus.fail_adr  = fadr_q;
    assign bus.match_cnt = match_q;
    assign bus.cycle_cnt = cycle_q;

`ifdef MWC_TRACE_EN
    // Trace matched/ignored writes and the verdict, then halt on a terminal state.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == StRun && !bus.start && bus.mem_write) begin
                if (hit)
                    $display("mwc: cycle %0d match  adr=%0h data=%0h", cycle_d,
                             bus.data_adr, bus.write_data);
                else if (ign)
                    $display("mwc: cycle %0d ignore adr=%0h data=%0h", cycle_d,
                             bus.data_adr, bus.write_data);
            end
            if (state_d != state_q && state_d == StPass) begin
                $display("Simulation succeeded");
                $stop;
            end else if (state_d != state_q && state_d == StFail) begin
                $display("Simulation failed, code %0d", code_d);
                $stop;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (NUM_EXP=4, TIMEOUT=20, IGNORE_ADR=96).
module tb_mem_write_checker;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_write_checker_if #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .TIMEOUT(20)) bus ();

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .IGNORE_ADR(96), .TIMEOUT(20)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'(idx); bus.cfg_addr = a; bus.cfg_data = d;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start(input int cnt);
        bus.start = 1'b1; bus.cfg_count = 3'(cnt);
        step();
        bus.start = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write = 1'b1; bus.data_adr = a; bus.write_data = d;
        step();
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code} !== 5'b0 ||
            bus.fail_adr !== 32'd0 || bus.match_cnt !== 3'd0 || bus.cycle_cnt !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs got d/p/f/c=%b%b%b%0d adr=%0d m=%0d cyc=%0d exp all 0",
                     bus.done, bus.pass, bus.fail, bus.fail_code, bus.fail_adr,
                     bus.match_cnt, bus.cycle_cnt);
        end
        step();
        reset = 1'b0;
        // mem_write in IDLE is ignored
        wr(32'd5, 32'd5);
        checks++;
        if ({bus.done, bus.fail} !== 2'b00) begin
            failures++;
            $display("FAIL idle_write got done/fail=%b%b exp 00", bus.done, bus.fail);
        end
    endtask

    task automatic test_ignore_then_match();
        cfg(0, 32'd100, 32'd7);
        do_start(1);
        checks++;
        if ({bus.done, bus.cycle_cnt} !== {1'b0, 5'd0}) begin
            failures++;
            $display("FAIL start_clear got done=%b cyc=%0d exp 0 0", bus.done, bus.cycle_cnt);
        end
        wr(32'd96, 32'd5);
        checks++;
        if ({bus.done, bus.match_cnt, bus.cycle_cnt} !== {1'b0, 3'd0, 5'd1}) begin
            failures++;
            $display("FAIL ignore_write got done=%b m=%0d cyc=%0d exp 0 0 1",
                     bus.done, bus.match_cnt, bus.cycle_cnt);
        end
        wr(32'd100, 32'd7);
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code, bus.match_cnt} !== 8'b110_00_001) begin
            failures++;
            $display("FAIL single_match got d/p/f=%b%b%b code=%0d m=%0d exp 110 0 1",
                     bus.done, bus.pass, bus.fail, bus.fail_code, bus.match_cnt);
        end
        wr(32'd200, 32'd1);
        checks++;
        if ({bus.pass, bus.fail, bus.cycle_cnt} !== {2'b10, 5'd2}) begin
            failures++;
            $display("FAIL pass_hold got p/f=%b%b cyc=%0d exp 10 2",
                     bus.pass, bus.fail, bus.cycle_cnt);
        end
    endtask

    task automatic test_mismatch();
        do_start(1);
        wr(32'd104, 32'd7);
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code} !== 5'b101_01 ||
            bus.fail_adr !== 32'd104) begin
            failures++;
            $display("FAIL mismatch got d/p/f=%b%b%b code=%0d adr=%0d exp 101 1 104",
                     bus.done, bus.pass, bus.fail, bus.fail_code, bus.fail_adr);
        end
    endtask

    task automatic test_timeout();
        do_start(1);
        repeat (19) step();
        checks++;
        if ({bus.done, bus.cycle_cnt} !== {1'b0, 5'd19}) begin
            failures++;
            $display("FAIL pre_timeout got done=%b cyc=%0d exp 0 19", bus.done, bus.cycle_cnt);
        end
        step();
        checks++;
        if ({bus.done, bus.fail, bus.fail_code, bus.cycle_cnt} !== {4'b1110, 5'd20} ||
            bus.fail_adr !== 32'd0) begin
            failures++;
            $display("FAIL timeout got d/f=%b%b code=%0d cyc=%0d adr=%0d exp 11 2 20 0",
                     bus.done, bus.fail, bus.fail_code, bus.cycle_cnt, bus.fail_adr);
        end
        do_start(1);
        repeat (19) step();
        wr(32'd100, 32'd7);
        checks++;
        if ({bus.pass, bus.fail, bus.fail_code, bus.cycle_cnt} !== {4'b1000, 5'd20}) begin
            failures++;
            $display("FAIL match_at_timeout got p/f=%b%b code=%0d cyc=%0d exp 10 0 20",
                     bus.pass, bus.fail, bus.fail_code, bus.cycle_cnt);
        end
    endtask

    task automatic test_order();
        do_reset();
        cfg(0, 32'd0, 32'd1);
        cfg(1, 32'd4, 32'd2);
        cfg(2, 32'd8, 32'd3);
        cfg(3, 32'd12, 32'd4);
        do_start(3);
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        checks++;
        if ({bus.done, bus.match_cnt} !== {1'b0, 3'd2}) begin
            failures++;
            $display("FAIL order_partial got done=%b m=%0d exp 0 2", bus.done, bus.match_cnt);
        end
        wr(32'd8, 32'd3);
        checks++;
        if ({bus.pass, bus.fail, bus.match_cnt} !== {2'b10, 3'd3}) begin
            failures++;
            $display("FAIL order_pass got p/f=%b%b m=%0d exp 10 3",
                     bus.pass, bus.fail, bus.match_cnt);
        end
        // cfg_we outside IDLE must not alter the table
        cfg(0, 32'd55, 32'd55);
        do_start(3);
        wr(32'd4, 32'd2);
        checks++;
        if ({bus.fail, bus.fail_code} !== 3'b101 || bus.fail_adr !== 32'd4) begin
            failures++;
            $display("FAIL order_wrong got f=%b code=%0d adr=%0d exp 1 1 4",
                     bus.fail, bus.fail_code, bus.fail_adr);
        end
        do_start(1);
        wr(32'd0, 32'd1);
        checks++;
        if (bus.pass !== 1'b1) begin
            failures++;
            $display("FAIL cfg_we_not_idle got pass=%b exp 1", bus.pass);
        end
    endtask

    task automatic test_bad_config();
        do_start(0);
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code} !== 5'b101_11 ||
            bus.match_cnt !== 3'd0) begin
            failures++;
            $display("FAIL cfg_zero got d/p/f=%b%b%b code=%0d m=%0d exp 101 3 0",
                     bus.done, bus.pass, bus.fail, bus.fail_code, bus.match_cnt);
        end
        do_start(5);
        checks++;
        if ({bus.fail, bus.fail_code} !== 3'b111) begin
            failures++;
            $display("FAIL cfg_over got f=%b code=%0d exp 1 3", bus.fail, bus.fail_code);
        end
        do_start(1);
        wr(32'd0, 32'd1);
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code} !== 5'b110_00) begin
            failures++;
            $display("FAIL cfg_restart got d/p/f=%b%b%b code=%0d exp 110 0",
                     bus.done, bus.pass, bus.fail, bus.fail_code);
        end
    endtask

    task automatic test_back_to_back();
        // start wins over a same-cycle mismatching write
        do_start(2);
        bus.start = 1'b1; bus.cfg_count = 3'd2;
        bus.mem_write = 1'b1; bus.data_adr = 32'd44; bus.write_data = 32'd9;
        step();
        bus.start = 1'b0; bus.mem_write = 1'b0;
        checks++;
        if ({bus.done, bus.fail, bus.cycle_cnt} !== {2'b00, 5'd0}) begin
            failures++;
            $display("FAIL start_priority got d/f=%b%b cyc=%0d exp 00 0",
                     bus.done, bus.fail, bus.cycle_cnt);
        end
        wr(32'd0, 32'd1);
        wr(32'd4, 32'd2);
        checks++;
        if ({bus.pass, bus.match_cnt, bus.cycle_cnt} !== {1'b1, 3'd2, 5'd2}) begin
            failures++;
            $display("FAIL back_to_back got p=%b m=%0d cyc=%0d exp 1 2 2",
                     bus.pass, bus.match_cnt, bus.cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(2);
        wr(32'd0, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_code} !== 5'b0 ||
            bus.match_cnt !== 3'd0 || bus.cycle_cnt !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_run got d/p/f=%b%b%b code=%0d m=%0d cyc=%0d exp all 0",
                     bus.done, bus.pass, bus.fail, bus.fail_code, bus.match_cnt,
                     bus.cycle_cnt);
        end
        step();
        reset = 1'b0;
        // Wiped table: entry 0 now expects (0,0)
        do_start(1);
        wr(32'd0, 32'd0);
        checks++;
        if ({bus.pass, bus.fail} !== 2'b10) begin
            failures++;
            $display("FAIL table_wiped got p/f=%b%b exp 10", bus.pass, bus.fail);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.cfg_count = '0; bus.start = 1'b0;
        bus.mem_write = 1'b0; bus.data_adr = '0; bus.write_data = '0;
        test_reset();
        test_ignore_then_match();
        test_mismatch();
        test_timeout();
        test_order();
        test_bad_config();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
